vc_intc: RTL and testbench
==========================

VC_INTC -- requirements
Module: vc_intc

Interface
REQ-001 SHALL have parameter NSRC, default 8, meaning the number of interrupt sources (legal range 1..8).
REQ-002 SHALL have parameter RV, default 16, meaning the I/O data width (RV >= 16).
REQ-003 SHALL have port clk, input, 1 bit: the clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port src, input, NSRC bits: interrupt request lines, synchronous to clk.
REQ-006 SHALL have port io_addr, input, 4 bits: register word index.
REQ-007 SHALL have port io_write, input, 1 bit: single-cycle write strobe.
REQ-008 SHALL have port io_read, input, 1 bit: single-cycle read strobe; only CLAIM reads have side effects.
REQ-009 SHALL have port io_wdata, input, RV bits: write data.
REQ-010 SHALL have port io_rdata, output, RV bits: combinational read data for io_addr; unused bits read 0.
REQ-011 SHALL have port interrupt, output, 1 bit: registered CPU interrupt request.

Function
REQ-012 SHALL implement this register map: 0 PENDING (read, write-1-to-clear); 1 ENABLE (read/write); 2 MODE (1=rising edge, 0=level; read/write); 3 CLAIM (read) / COMPLETE (write); 4 PRIO (2 bits per source, source i at [2i+1:2i]; read/write); 5 THRESH ([1:0]; read/write); 6 INSERVICE (read-only); all other indices read 0 and ignore writes.
REQ-013 SHALL register src into src_d each cycle; an edge source sets pending[i] on a cycle where src[i]=1 and src_d[i]=0.
REQ-014 SHALL load level-source pending[i] from src[i] every cycle; W1C and claim have no effect on level sources.
REQ-015 SHALL give set priority over clear when an edge set coincides with a W1C or claim clear of the same bit in one cycle.
REQ-016 SHALL define eligible[i] = pending[i] & enable[i] & ~inservice[i] & (prio[i] > thresh).
REQ-017 SHALL select as winner the eligible source with the highest prio; ties go to the lowest index.
REQ-018 SHALL register interrupt as |eligible, so it asserts 2 cycles after an edge src rise and deasserts 1 cycle after eligible clears.
REQ-019 SHALL make a CLAIM read return winner+1 (1..NSRC), or 0 when no source is eligible.
REQ-020 SHALL, on a CLAIM read with winner w, set inservice[w] and clear pending[w] if w is an edge source, at the same clock edge.
REQ-021 SHALL, on a COMPLETE write with io_wdata[3:0]=k where 1<=k<=NSRC, clear inservice[k-1]; other values SHALL be ignored.
REQ-022 SHALL keep a source that is in service ineligible, while other sources SHALL remain claimable (nesting).
REQ-023 SHALL let a new edge set pending on a source that is in service; it is claimable after completion.
REQ-024 SHALL have no effect for a CLAIM read returning 0.
REQ-025 SHALL apply a CLAIM read and a COMPLETE write to the same source in one cycle with claim first, then complete (net: inservice clear).
REQ-026 SHALL ignore register bits above NSRC on write and read them as 0.

Reset
REQ-027 SHALL, while reset=1, clear pending, enable, mode, prio, thresh, inservice and interrupt to 0, and set io_rdata to the map value for io_addr (0 except ENABLE/… all zero).
REQ-028 SHALL load src_d from src during reset, so a line held high across reset produces no edge.
REQ-029 SHALL, on reset asserted mid-claim or mid-service, discard all in-service state; strobes during reset SHALL be ignored.

Verification
REQ-030 SHALL be verified by: MODE=0x01, ENABLE=0x01, PRIO=0x0001, THRESH=0; pulse src[0] 1 cycle -> PENDING=0x01 next cycle, interrupt=1 two cycles after rise; CLAIM=1; then interrupt=0 and INSERVICE=0x01.
REQ-031 SHALL be verified by: sources 2 and 5 edge-pending, both enabled, prio 3 each -> CLAIM=3; second CLAIM=6; COMPLETE 3 -> INSERVICE=0x20.
REQ-032 SHALL be verified by: level source 1, prio 2, THRESH=2 -> interrupt stays 0; THRESH=1 -> interrupt=1 one cycle later; drop src[1] -> interrupt=0 two cycles later.
REQ-033 SHALL be verified by: W1C of bit 4 in the same cycle as an edge on src[4] -> PENDING bit 4 remains 1.
REQ-034 SHALL be verified by: src[7] held high through reset release -> PENDING=0, interrupt=0; COMPLETE 0 and 9 -> no change.
REQ-035 SHALL be verified by: NSRC=3 build; writing ENABLE=0xFFFF -> reads 0x0007.

Source files
------------

// File: rtl/vc_intc.sv
// ============================================================================
//  Module   : vc_intc
//  Brief    : Small vectored interrupt controller: edge/level sources, 2-bit
//             priorities, threshold, claim/complete handshake with nesting.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vc_intc #(
    parameter int NSRC = 8,
    parameter int RV   = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic [3:0]      io_addr,
    input  logic            io_write,
    input  logic            io_read,
    input  logic [RV-1:0]   io_wdata,
    output logic [RV-1:0]   io_rdata,
    output logic            interrupt
);

    localparam logic [3:0] C_ADDR_PENDING   = 4'd0;
    localparam logic [3:0] C_ADDR_ENABLE    = 4'd1;
    localparam logic [3:0] C_ADDR_MODE      = 4'd2;
    localparam logic [3:0] C_ADDR_CLAIM     = 4'd3;
    localparam logic [3:0] C_ADDR_PRIO      = 4'd4;
    localparam logic [3:0] C_ADDR_THRESH    = 4'd5;
    localparam logic [3:0] C_ADDR_INSERVICE = 4'd6;
    localparam logic [3:0] C_NSRC           = 4'(NSRC);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [NSRC-1:0]   src_dly_q;
    logic [NSRC-1:0]   pending_q,   pending_d;
    logic [NSRC-1:0]   enable_q,    enable_d;
    logic [NSRC-1:0]   mode_q,      mode_d;
    logic [NSRC-1:0]   inservice_q, inservice_d;
    logic [2*NSRC-1:0] prio_q,      prio_d;
    logic [1:0]        thresh_q,    thresh_d;
    logic              interrupt_q;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] edge_rise;
    logic [NSRC-1:0] w1c_clr;
    logic [NSRC-1:0] claim_set;
    logic [NSRC-1:0] complete_clr;
    logic            any_eligible;
    logic [3:0]      win_idx;
    logic [1:0]      win_prio;
    logic [3:0]      claim_id;
    logic [3:0]      complete_id;
    logic            wr_pending;
    logic            wr_enable;
    logic            wr_mode;
    logic            wr_prio;
    logic            wr_thresh;
    logic            claim_fire;
    logic            complete_fire;
    logic            unused_wdata;

    assign unused_wdata = ^io_wdata;

    // Register strobe decode
    assign wr_pending    = io_write & (io_addr == C_ADDR_PENDING);
    assign wr_enable     = io_write & (io_addr == C_ADDR_ENABLE);
    assign wr_mode       = io_write & (io_addr == C_ADDR_MODE);
    assign wr_prio       = io_write & (io_addr == C_ADDR_PRIO);
    assign wr_thresh     = io_write & (io_addr == C_ADDR_THRESH);
    assign complete_id   = io_wdata[3:0];
    assign complete_fire = io_write & (io_addr == C_ADDR_CLAIM)
                         & (complete_id != 4'd0) & (complete_id <= C_NSRC);
    assign claim_fire    = io_read & (io_addr == C_ADDR_CLAIM) & any_eligible;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NSRC; i++) begin
            eligible[i] = pending_q[i] & enable_q[i] & ~inservice_q[i]
                        & (prio_q[2*i +: 2] > thresh_q);
        end
    end

    // Strict '>' keeps the lowest index among equal priorities
    always_comb begin
        any_eligible = 1'b0;
        win_idx      = 4'd0;
        win_prio     = 2'd0;
        for (int i = 0; i < NSRC; i++) begin
            if (eligible[i] && (!any_eligible || (prio_q[2*i +: 2] > win_prio))) begin
                any_eligible = 1'b1;
                win_idx      = 4'(i);
                win_prio     = prio_q[2*i +: 2];
            end
        end
    end

    assign claim_id = any_eligible ? (win_idx + 4'd1) : 4'd0;

    always_comb begin
        claim_set    = '0;
        complete_clr = '0;
        for (int i = 0; i < NSRC; i++) begin
            claim_set[i]    = claim_fire & (win_idx == 4'(i));
            complete_clr[i] = complete_fire & (complete_id == 4'(i + 1));
        end
    end

    assign edge_rise = src & ~src_dly_q;
    assign w1c_clr   = wr_pending ? io_wdata[NSRC-1:0] : '0;

    // ------------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------------
    always_comb begin
        // Edge set overrides a simultaneous W1C or claim clear
        pending_d   = (mode_q & (edge_rise | (pending_q & ~(w1c_clr | claim_set))))
                    | (~mode_q & src);
        // Claim then complete: a same-cycle complete of the winner leaves it idle
        inservice_d = (inservice_q | claim_set) & ~complete_clr;
        enable_d    = wr_enable ? io_wdata[NSRC-1:0]   : enable_q;
        mode_d      = wr_mode   ? io_wdata[NSRC-1:0]   : mode_q;
        prio_d      = wr_prio   ? io_wdata[2*NSRC-1:0] : prio_q;
        thresh_d    = wr_thresh ? io_wdata[1:0]        : thresh_q;
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // Tracking src through reset avoids a false edge on release
        src_dly_q <= src;
        if (reset) begin
            pending_q   <= '0;
            enable_q    <= '0;
            mode_q      <= '0;
            inservice_q <= '0;
            prio_q      <= '0;
            thresh_q    <= '0;
            interrupt_q <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            enable_q    <= enable_d;
            mode_q      <= mode_d;
            inservice_q <= inservice_d;
            prio_q      <= prio_d;
            thresh_q    <= thresh_d;
            interrupt_q <= |eligible;
        end
    end

    assign interrupt = interrupt_q;

    // ------------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------------
    always_comb begin
        io_rdata = '0;
        if (!reset) begin
            case (io_addr)
                C_ADDR_PENDING:   io_rdata[NSRC-1:0]   = pending_q;
                C_ADDR_ENABLE:    io_rdata[NSRC-1:0]   = enable_q;
                C_ADDR_MODE:      io_rdata[NSRC-1:0]   = mode_q;
                C_ADDR_CLAIM:     io_rdata[3:0]        = claim_id;
                C_ADDR_PRIO:      io_rdata[2*NSRC-1:0] = prio_q;
                C_ADDR_THRESH:    io_rdata[1:0]        = thresh_q;
                C_ADDR_INSERVICE: io_rdata[NSRC-1:0]   = inservice_q;
                default:          io_rdata             = '0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vc_intc.sv
// ============================================================================
//  Module   : tb_vc_intc
//  Brief    : Self-checking bench for vc_intc: directed tables, corner
//             sequences and randomized traffic against a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vc_intc;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  src;
    logic [3:0]  io_addr;
    logic        io_write;
    logic        io_read;
    logic [15:0] io_wdata;
    logic [15:0] io_rdata;
    logic        interrupt;

    logic [2:0]  src3;
    logic [3:0]  addr3;
    logic        wr3;
    logic        rd3;
    logic [15:0] wdata3;
    logic [15:0] rdata3;
    logic        irq3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    vc_intc #(.NSRC(8), .RV(16)) dut (
        .clk(clk), .reset(reset), .src(src), .io_addr(io_addr),
        .io_write(io_write), .io_read(io_read), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .interrupt(interrupt)
    );

    vc_intc #(.NSRC(3), .RV(16)) dut3 (
        .clk(clk), .reset(reset), .src(src3), .io_addr(addr3),
        .io_write(wr3), .io_read(rd3), .io_wdata(wdata3),
        .io_rdata(rdata3), .interrupt(irq3)
    );

    typedef struct {
        logic [3:0]  addr;
        logic        wr;
        logic        rd;
        logic [15:0] wdata;
        logic [7:0]  src;
        logic [15:0] exp_rdata;
        logic        exp_irq;
    } vec_t;

    function automatic vec_t mk(logic [3:0] a, logic w, logic r, logic [15:0] d,
                                logic [7:0] s, logic [15:0] er, logic ei);
        vec_t v;
        v.addr = a; v.wr = w; v.rd = r; v.wdata = d; v.src = s;
        v.exp_rdata = er; v.exp_irq = ei;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(logic [3:0] a, logic [15:0] d);
        io_addr  = a;
        io_wdata = d;
        io_write = 1'b1;
        tick();
        io_write = 1'b0;
    endtask

    task automatic rd_claim(output logic [15:0] v);
        io_addr = 4'd3;
        io_read = 1'b1;
        #1;
        v = io_rdata;
        tick();
        io_read = 1'b0;
    endtask

    task automatic check_reg(string name, logic [3:0] a, logic [15:0] exp);
        io_addr = a;
        #1;
        check(name, io_rdata, exp);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        io_write = 1'b0;
        io_read  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Reference model: architectural state held as plain arrays/integers
    task automatic run_random(int cycles);
        bit [7:0] m_pend, m_en, m_mode, m_ins, m_prev, npend;
        int       m_prio[8];
        int       m_thr;
        bit       m_irq;
        int       best, k;
        bit       r_rst, claim, rise, clr;
        logic [15:0] exp;
        m_pend = '0; m_en = '0; m_mode = '0; m_ins = '0; m_prev = '0;
        m_thr = 0; m_irq = 1'b0;
        foreach (m_prio[i]) m_prio[i] = 0;
        for (int c = 0; c < cycles; c++) begin
            r_rst    = (c == 0) || ($urandom_range(0, 299) == 0);
            reset    = r_rst;
            src      = src ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            io_addr  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(7, 15))
                                                   : 4'($urandom_range(0, 6));
            io_write = ($urandom_range(0, 3) == 0);
            io_read  = ($urandom_range(0, 2) == 0);
            io_wdata = 16'($urandom);
            if (io_addr == 4'd3) io_wdata[3:0] = 4'($urandom_range(0, 9));
            if (io_addr == 4'd5) io_wdata[1:0] = 2'($urandom_range(0, 1));
            #1;
            best = -1;
            for (int i = 0; i < 8; i++) begin
                if (m_pend[i] && m_en[i] && !m_ins[i] && (m_prio[i] > m_thr)) begin
                    if (best < 0 || m_prio[i] > m_prio[best]) best = i;
                end
            end
            exp = 16'h0;
            if (!r_rst) begin
                case (io_addr)
                    4'd0: exp = {8'h0, m_pend};
                    4'd1: exp = {8'h0, m_en};
                    4'd2: exp = {8'h0, m_mode};
                    4'd3: exp = 16'(best + 1);
                    4'd4: for (int i = 0; i < 8; i++) exp = exp | 16'(m_prio[i] << (2 * i));
                    4'd5: exp = 16'(m_thr);
                    4'd6: exp = {8'h0, m_ins};
                    default: exp = 16'h0;
                endcase
            end
            check("rnd_rdata", io_rdata, exp);
            check("rnd_irq", interrupt, m_irq);
            if (r_rst) begin
                m_pend = '0; m_en = '0; m_mode = '0; m_ins = '0;
                m_thr = 0; m_irq = 1'b0;
                foreach (m_prio[i]) m_prio[i] = 0;
            end else begin
                claim = io_read && (io_addr == 4'd3) && (best >= 0);
                for (int i = 0; i < 8; i++) begin
                    if (!m_mode[i]) begin
                        npend[i] = src[i];
                    end else begin
                        rise = src[i] && !m_prev[i];
                        clr  = (io_write && io_addr == 4'd0 && io_wdata[i]) || (claim && best == i);
                        npend[i] = rise || (m_pend[i] && !clr);
                    end
                end
                if (claim) m_ins[best] = 1'b1;
                k = int'(io_wdata[3:0]);
                if (io_write && io_addr == 4'd3 && k >= 1 && k <= 8) m_ins[k-1] = 1'b0;
                m_irq = (best >= 0);
                if (io_write) begin
                    case (io_addr)
                        4'd1: m_en   = io_wdata[7:0];
                        4'd2: m_mode = io_wdata[7:0];
                        4'd4: for (int i = 0; i < 8; i++) m_prio[i] = int'(io_wdata[2*i +: 2]);
                        4'd5: m_thr  = int'(io_wdata[1:0]);
                        default: ;
                    endcase
                end
                m_pend = npend;
            end
            m_prev = src;
            tick();
        end
        reset    = 1'b0;
        io_write = 1'b0;
        io_read  = 1'b0;
    endtask

    initial begin
        vec_t        vecs[$];
        logic [15:0] v;

        reset = 1'b1; src = '0; io_addr = '0; io_write = 1'b0; io_read = 1'b0; io_wdata = '0;
        src3 = '0; addr3 = '0; wr3 = 1'b0; rd3 = 1'b0; wdata3 = '0;

        // Reset state
        do_reset();
        for (int a = 0; a < 8; a++) begin
            check_reg($sformatf("reset_reg%0d", a), 4'(a), 16'h0);
            tick();
        end
        check("reset_irq", interrupt, 1'b0);

        // Single edge source: setup, pulse, claim
        vecs.push_back(mk(4'd2, 1, 0, 16'h0001, 8'h00, 16'h0000, 1'b0));
        vecs.push_back(mk(4'd1, 1, 0, 16'h0001, 8'h00, 16'h0000, 1'b0));
        vecs.push_back(mk(4'd4, 1, 0, 16'h0001, 8'h00, 16'h0000, 1'b0));
        vecs.push_back(mk(4'd5, 1, 0, 16'h0000, 8'h00, 16'h0000, 1'b0));
        vecs.push_back(mk(4'd0, 0, 0, 16'h0000, 8'h01, 16'h0000, 1'b0));
        vecs.push_back(mk(4'd0, 0, 0, 16'h0000, 8'h00, 16'h0001, 1'b0));
        vecs.push_back(mk(4'd3, 0, 0, 16'h0000, 8'h00, 16'h0001, 1'b1));
        vecs.push_back(mk(4'd3, 0, 1, 16'h0000, 8'h00, 16'h0001, 1'b1));
        vecs.push_back(mk(4'd6, 0, 0, 16'h0000, 8'h00, 16'h0001, 1'b1));
        vecs.push_back(mk(4'd0, 0, 0, 16'h0000, 8'h00, 16'h0000, 1'b0));
        vecs.push_back(mk(4'd6, 0, 0, 16'h0000, 8'h00, 16'h0001, 1'b0));
        for (int i = 0; i < vecs.size(); i++) begin
            io_addr = vecs[i].addr; io_write = vecs[i].wr; io_read = vecs[i].rd;
            io_wdata = vecs[i].wdata; src = vecs[i].src;
            #1;
            check($sformatf("vec%0d_rdata", i), io_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_irq", i), interrupt, vecs[i].exp_irq);
            tick();
        end
        io_write = 1'b0; io_read = 1'b0;

        // Equal priority tie, nesting, complete
        do_reset();
        wr_reg(4'd2, 16'h0024); wr_reg(4'd1, 16'h0024);
        wr_reg(4'd4, 16'h0C30); wr_reg(4'd5, 16'h0000);
        src = 8'h24; tick(); src = 8'h00; tick();
        check("tie_irq", interrupt, 1'b1);
        rd_claim(v); check("tie_claim1", v, 16'd3);
        rd_claim(v); check("tie_claim2", v, 16'd6);
        wr_reg(4'd3, 16'h0003);
        check("tie_irq_off", interrupt, 1'b0);
        check_reg("tie_inservice", 4'd6, 16'h0020);
        tick();

        // Reset in the middle of service, with strobes active
        reset = 1'b1; io_read = 1'b1; io_write = 1'b1; io_wdata = 16'hFFFF;
        for (int a = 0; a < 7; a++) check_reg($sformatf("rst_rdata%0d", a), 4'(a), 16'h0);
        io_addr = 4'd1;
        tick(); tick();
        reset = 1'b0; io_read = 1'b0; io_write = 1'b0;
        check_reg("rst_inservice", 4'd6, 16'h0);
        check_reg("rst_enable", 4'd1, 16'h0);
        check("rst_irq", interrupt, 1'b0);

        // Level source and threshold
        do_reset();
        wr_reg(4'd1, 16'h0002); wr_reg(4'd4, 16'h0008); wr_reg(4'd5, 16'h0002);
        src = 8'h02; tick(); tick(); tick();
        check("lvl_irq_thresh", interrupt, 1'b0);
        wr_reg(4'd0, 16'h0002);
        check_reg("lvl_w1c_noeffect", 4'd0, 16'h0002);
        wr_reg(4'd5, 16'h0001);
        check("lvl_irq_t0", interrupt, 1'b0);
        tick(); check("lvl_irq_t1", interrupt, 1'b1);
        src = 8'h00;
        tick(); check("lvl_drop_t1", interrupt, 1'b1);
        tick(); check("lvl_drop_t2", interrupt, 1'b0);

        // Edge set beats same-cycle W1C
        do_reset();
        wr_reg(4'd2, 16'h0010);
        src = 8'h10; tick(); src = 8'h00; tick();
        check_reg("w1c_pre", 4'd0, 16'h0010);
        src = 8'h10; io_addr = 4'd0; io_wdata = 16'h0010; io_write = 1'b1;
        tick(); io_write = 1'b0;
        check_reg("w1c_setwins", 4'd0, 16'h0010);
        wr_reg(4'd0, 16'h0010);
        check_reg("w1c_clear", 4'd0, 16'h0000);

        // Line held high across reset; invalid completes
        reset = 1'b1; src = 8'h80; tick(); tick(); reset = 1'b0;
        check_reg("hold_pending", 4'd0, 16'h0000);
        check("hold_irq", interrupt, 1'b0);
        tick(); tick();
        check("hold_irq_late", interrupt, 1'b0);
        wr_reg(4'd1, 16'h0080); wr_reg(4'd4, 16'h4000); tick();
        rd_claim(v); check("hold_claim", v, 16'd8);
        check_reg("hold_ins", 4'd6, 16'h0080);
        check_reg("hold_lvl_pend", 4'd0, 16'h0080);
        wr_reg(4'd3, 16'h0000); check_reg("complete0", 4'd6, 16'h0080);
        wr_reg(4'd3, 16'h0009); check_reg("complete9", 4'd6, 16'h0080);
        wr_reg(4'd3, 16'h0008); check_reg("complete8", 4'd6, 16'h0000);
        tick();
        io_addr = 4'd3; io_read = 1'b1; io_write = 1'b1; io_wdata = 16'h0008;
        #1; check("claimcomp_rdata", io_rdata, 16'd8);
        tick(); io_read = 1'b0; io_write = 1'b0;
        check_reg("claimcomp_ins", 4'd6, 16'h0000);
        src = 8'h00;

        // Narrow build masks unused bits
        addr3 = 4'd1; wdata3 = 16'hFFFF; wr3 = 1'b1; tick(); wr3 = 1'b0; #1;
        check("n3_enable", rdata3, 16'h0007);
        addr3 = 4'd4; wr3 = 1'b1; tick(); wr3 = 1'b0; #1;
        check("n3_prio", rdata3, 16'h003F);
        addr3 = 4'd2; wr3 = 1'b1; tick(); wr3 = 1'b0; #1;
        check("n3_mode", rdata3, 16'h0007);
        tick();

        run_random(3000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
